// File: rtl/wu_writeback_if.sv
// Handshake bundle between the subtractor result stream, the writeback block
// and the weight memory write port.
interface wu_writeback_if #(
   parameter int WORD_W = 512,
   parameter int ADDR_W = 10
);
   logic              res_valid;
   logic [WORD_W-1:0] res_data;
   logic              res_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_ready;

   modport master (
      output res_valid, res_data, mem_ready,
      input  res_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  res_valid, res_data, mem_ready,
      output res_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/wu_writeback.sv
// Buffers updated weight vectors in a small first-word-fall-through FIFO and
// writes them to consecutive weight-memory addresses starting at base_addr.
module wu_writeback #(
   parameter int dataWidth   = 32,
   parameter int pactivation = 16,
   parameter int addrWidth   = 10,
   parameter int fifoDepth   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [addrWidth-1:0] base_addr,
   input  logic [addrWidth:0]   num_words,
   wu_writeback_if.slave        bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam int WORD_W = dataWidth * pactivation;
   localparam int PTR_W  = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [addrWidth:0]   W_ZERO  = (addrWidth+1)'(1'b0);
   localparam logic [addrWidth:0]   W_ONE   = (addrWidth+1)'(1'b1);
   localparam logic [addrWidth-1:0] A_ONE   = addrWidth'(1'b1);
   localparam logic [PTR_W-1:0]     P_ONE   = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0]     C_ZERO  = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0]     C_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0]     C_DEPTH = CNT_W'(fifoDepth);

   logic [1:0]           state_r, state_s;
   logic [addrWidth:0]   nw_r, rx_cnt_r, wr_cnt_r;
   logic [addrWidth-1:0] addr_r;
   logic                 busy_r, done_r, err_r;

   logic [WORD_W-1:0]    fifo_q [fifoDepth];
   logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]     count_r, count_s;
   logic                 full_r, nonempty_r;

   logic                 res_ready_s, push_s, pop_s, launch_s;

   // Handshake qualifiers; the full flag is registered so a pop frees a slot one cycle later.
   always_comb begin
      res_ready_s = (state_r == RUN) && !full_r && (rx_cnt_r < nw_r);
      push_s      = bus.res_valid && res_ready_s;
      pop_s       = nonempty_r && bus.mem_ready;
      launch_s    = (state_r == IDLE) && start;
   end

   // Transfer sequencing.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (num_words == W_ZERO) state_s = DONE;
               else                     state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (pop_s && ((wr_cnt_r + W_ONE) == nw_r)) state_s = DONE;
            else                                       state_s = RUN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // FIFO occupancy after this cycle's push/pop.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + C_ONE;
         2'b01:   count_s = count_r - C_ONE;
         default: count_s = count_r;
      endcase
   end

   // FIFO pointers and registered status flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= C_ZERO;
         full_r     <= 1'b0;
         nonempty_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + P_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + P_ONE;
         count_r    <= count_s;
         full_r     <= (count_s == C_DEPTH);
         nonempty_r <= (count_s != C_ZERO);
      end
   end

   // FIFO storage; contents are meaningless until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (push_s) fifo_q[wr_ptr_r] <= bus.res_data;
   end

   // Control state, counters, write address and status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         nw_r     <= W_ZERO;
         rx_cnt_r <= W_ZERO;
         wr_cnt_r <= W_ZERO;
         addr_r   <= {addrWidth{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == RUN);
         done_r  <= (state_s == DONE);
         if (launch_s) begin
            nw_r     <= num_words;
            rx_cnt_r <= W_ZERO;
            wr_cnt_r <= W_ZERO;
            addr_r   <= base_addr;
         end else begin
            if (push_s) rx_cnt_r <= rx_cnt_r + W_ONE;
            if (pop_s) begin
               wr_cnt_r <= wr_cnt_r + W_ONE;
               addr_r   <= addr_r + A_ONE;
            end
         end
         // A stray result outside RUN wins over the clear from a same-cycle start.
         if (bus.res_valid && (state_r != RUN)) err_r <= 1'b1;
         else if (launch_s)                     err_r <= 1'b0;
      end
   end

   assign bus.res_ready = res_ready_s;
   assign bus.mem_we    = nonempty_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = nonempty_r ? fifo_q[rd_ptr_r] : {WORD_W{1'b0}};
   assign busy          = busy_r;
   assign done          = done_r;
   assign err           = err_r;
endmodule

// File: doc/wu_writeback.md
Name: wu_writeback

Overview:
- Write-side companion to the vector weight-update subtractor.
- Accepts updated weight vectors (W - lr*dW) from the subtractor pipeline via valid/ready, buffers them in a small FIFO, and writes them into a contiguous weight-memory region.
- Addresses run from base_addr in strict arrival order. Pulses done when the last word has been accepted by memory.

Parameters:
dataWidth, 32, bits per floating-point element
pactivation, 16, elements per vector word (word width = dataWidth*pactivation)
addrWidth, 10, weight-memory word-address width
fifoDepth, 4, result buffer depth in vector words (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset (rst==0 resets on clk rising edge)
start  in  1  one-cycle pulse; begins a transfer (honoured only in IDLE)
base_addr  in  addrWidth  first write address, latched on start
num_words  in  addrWidth+1  vector words in transfer, latched on start
res_valid  in  1  subtractor result valid
res_data  in  dataWidth*pactivation  subtractor result vector
res_ready  out  1  block can accept res_data this cycle
mem_we  out  1  write request to weight memory
mem_addr  out  addrWidth  write address
mem_wdata  out  dataWidth*pactivation  write data
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer
err  out  1  sticky: res_valid seen while not in RUN

Behaviour:
- Reset values (rst==0 at clk edge): state IDLE, FIFO empty, rx_cnt=0, wr_cnt=0, res_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
- A reset mid-transfer discards FIFO contents. No write occurs after the reset edge.
- States:
  - IDLE -> RUN on start with num_words!=0: latch base_addr and num_words, clear rx_cnt, wr_cnt and err.
  - IDLE -> DONE on start with num_words==0 (no writes issued).
  - RUN -> DONE when wr_cnt reaches num_words, i.e. after the final mem_we&&mem_ready.
  - DONE -> IDLE unconditionally after one cycle.
- start outside IDLE is ignored.
- busy=1 in RUN only; done=1 in DONE only.
- Input handshake:
  - res_ready = (state==RUN) && !fifo_full && (rx_cnt<num_words).
  - fifo_full is the registered full flag, so a same-cycle pop does not raise res_ready.
  - Transfer occurs when res_valid && res_ready; the word is pushed and rx_cnt increments.
  - res_valid while state!=RUN sets err; the data is dropped.
- Output handshake:
  - mem_we = FIFO non-empty, registered head, first-word-fall-through.
  - mem_wdata = FIFO head.
  - mem_addr = (base_addr + wr_cnt) mod 2^addrWidth; the address wraps silently.
  - Write retires when mem_we && mem_ready: pop the FIFO, increment wr_cnt.
  - While mem_ready==0, mem_we, mem_addr and mem_wdata hold stable.
- Latency: a word accepted in cycle N appears on mem_we/mem_wdata in cycle N+1 if the FIFO was empty. Otherwise it follows in order.
- Throughput: one word/cycle sustained when mem_ready is held high.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both take effect.
- Full FIFO: res_ready=0 until a pop has registered.
- Empty FIFO with a push: no write issued that cycle.
- Width rules: counters are addrWidth+1 bits, so num_words = 2^addrWidth is legal (full-memory sweep).
- Data passes through bit-exact; no arithmetic is applied to res_data.

Test Plan:
1. Reset then start (base_addr=0x010, num_words=3), res_valid held high with vectors V0..V2, mem_ready=1 -> writes V0@0x010, V1@0x011, V2@0x012 on consecutive cycles; done pulses exactly once, 1 cycle after the last write; busy falls with done.
2. num_words=6, mem_ready=0 for 10 cycles, fifoDepth=4 -> res_ready drops after 4 accepts; mem_we/addr/data stay stable; after mem_ready=1 all 6 words are written in order; no word is lost or duplicated.
3. base_addr=0x3FE, num_words=4 (addrWidth=10) -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
4. start with num_words=0 -> no mem_we, done=1 on the following cycle, return to IDLE; res_valid pulsed while IDLE -> err=1, cleared on the next start.
5. Random res_valid and mem_ready (50% each), num_words=64 -> memory image matches the sent sequence exactly; done is a single pulse.
6. Drive rst=0 after 2 of 5 writes, then release -> all outputs at reset values; no mem_we until a new start; a fresh 2-word transfer completes correctly.
